// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: instruction kinds, width helpers and default XLEN.
package rob_pkg;

  localparam int unsigned ROB_XLEN = 32;

  typedef enum logic [1:0] {
    KIND_ALU    = 2'd0,
    KIND_STORE  = 2'd1,
    KIND_BRANCH = 2'd2,
    KIND_JALR   = 2'd3
  } rob_kind_e;

  function automatic int unsigned rob_tag_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned rob_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Width of a port-index field; never zero, even for a single port.
  function automatic int unsigned rob_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rob_wb_merge.sv
// Priority writeback select for one tag: reports whether any port hits it and which port
// wins, with the lowest-numbered port taking precedence.
module rob_wb_merge
  import rob_pkg::*;
#(
  parameter int unsigned NWB   = 2,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned PW   = rob_idx_w(NWB)
) (
  input  logic [TAG_W-1:0]     sel_tag,
  input  logic [NWB-1:0]       wb_valid,
  input  logic [NWB*TAG_W-1:0] wb_tag,
  output logic                 hit_c,
  output logic [PW-1:0]        sel_c
);

  // Scan from the highest port down so the lowest matching port is written last.
  always_comb begin
    hit_c = 1'b0;
    sel_c = '0;
    for (int p = int'(NWB) - 1; p >= 0; p--) begin
      if (wb_valid[p] && (wb_tag[p*TAG_W +: TAG_W] == sel_tag)) begin
        hit_c = 1'b1;
        sel_c = PW'(p);
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer with in-order commit, branch/JALR flush and operand lookup.
// Define ROB_WB_BYPASS_EN to forward same-cycle writebacks onto the lookup ports.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NWB    = 2,
  parameter int unsigned XLEN   = ROB_XLEN,
  localparam int unsigned TAG_W = rob_tag_w(DEPTH),
  localparam int unsigned CNT_W = rob_cnt_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  output logic [TAG_W-1:0]     alloc_tag,
  input  logic [1:0]           alloc_kind,
  input  logic [4:0]           alloc_rd,
  input  logic [XLEN-1:0]      alloc_pc,
  input  logic                 alloc_pred_taken,
  input  logic [NWB-1:0]       wb_valid,
  input  logic [NWB*TAG_W-1:0] wb_tag,
  input  logic [NWB*XLEN-1:0]  wb_value,
  input  logic [NWB*XLEN-1:0]  wb_target,
  input  logic [NWB-1:0]       wb_taken,
  input  logic [2*TAG_W-1:0]   rd_tag,
  output logic [1:0]           rd_ready,
  output logic [2*XLEN-1:0]    rd_value,
  output logic                 commit_reg_en,
  output logic [4:0]           commit_rd,
  output logic [TAG_W-1:0]     commit_tag,
  output logic [XLEN-1:0]      commit_value,
  output logic                 commit_store_en,
  output logic [XLEN-1:0]      commit_store_addr,
  output logic [XLEN-1:0]      commit_store_data,
  output logic                 flush,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 pred_upd_en,
  output logic [XLEN-1:0]      pred_upd_pc,
  output logic                 pred_upd_taken,
  output logic [CNT_W-1:0]     count
);

  localparam int unsigned PW = rob_idx_w(NWB);

  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] occ_q, occ_d, done_q, done_d, pred_q, pred_d, taken_q, taken_d;
  rob_kind_e        kind_q [DEPTH];
  rob_kind_e        kind_d [DEPTH];
  logic [4:0]       rd_q [DEPTH];
  logic [4:0]       rd_d [DEPTH];
  logic [XLEN-1:0]  pc_q [DEPTH];
  logic [XLEN-1:0]  pc_d [DEPTH];
  logic [XLEN-1:0]  value_q [DEPTH];
  logic [XLEN-1:0]  value_d [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];
  logic [XLEN-1:0]  target_d [DEPTH];

  logic             co_reg_en_q, co_reg_en_d, co_st_en_q, co_st_en_d;
  logic             co_flush_q, co_flush_d, co_pu_en_q, co_pu_en_d, co_pu_taken_q, co_pu_taken_d;
  logic [4:0]       co_rd_q, co_rd_d;
  logic [TAG_W-1:0] co_tag_q, co_tag_d;
  logic [XLEN-1:0]  co_value_q, co_value_d, co_st_addr_q, co_st_addr_d, co_st_data_q, co_st_data_d;
  logic [XLEN-1:0]  co_redirect_q, co_redirect_d, co_pu_pc_q, co_pu_pc_d;

  logic             commit_c, flush_c, alloc_c, mispred_c;
  logic [DEPTH-1:0] ewb_hit;
  logic [PW-1:0]    ewb_sel [DEPTH];

  assign alloc_ready = (count_q < CNT_W'(DEPTH));
  assign alloc_tag   = tail_q;

  for (genvar e = 0; e < int'(DEPTH); e++) begin : g_ent
    rob_wb_merge #(.NWB(NWB), .TAG_W(TAG_W)) u_merge (
      .sel_tag (TAG_W'(e)),
      .wb_valid(wb_valid),
      .wb_tag  (wb_tag),
      .hit_c   (ewb_hit[e]),
      .sel_c   (ewb_sel[e])
    );
  end

  for (genvar r = 0; r < 2; r++) begin : g_rd
    logic [TAG_W-1:0] tag;
    assign tag = rd_tag[r*TAG_W +: TAG_W];
`ifdef ROB_WB_BYPASS_EN
    logic          hit;
    logic [PW-1:0] sel;
    rob_wb_merge #(.NWB(NWB), .TAG_W(TAG_W)) u_byp (
      .sel_tag (tag),
      .wb_valid(wb_valid),
      .wb_tag  (wb_tag),
      .hit_c   (hit),
      .sel_c   (sel)
    );
    // Forward only writebacks that will actually land this edge.
    assign rd_ready[r] = (rdy && hit && occ_q[tag]) ? 1'b1 : done_q[tag];
    assign rd_value[r*XLEN +: XLEN] = (rdy && hit && occ_q[tag]) ?
                                      wb_value[int'(sel)*XLEN +: XLEN] : value_q[tag];
`else
    assign rd_ready[r]              = done_q[tag];
    assign rd_value[r*XLEN +: XLEN] = value_q[tag];
`endif
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    occ_d   = occ_q;
    done_d  = done_q;
    pred_d  = pred_q;
    taken_d = taken_q;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      kind_d[e]   = kind_q[e];
      rd_d[e]     = rd_q[e];
      pc_d[e]     = pc_q[e];
      value_d[e]  = value_q[e];
      target_d[e] = target_q[e];
    end
    co_reg_en_d   = 1'b0;
    co_st_en_d    = 1'b0;
    co_flush_d    = 1'b0;
    co_pu_en_d    = 1'b0;
    co_pu_taken_d = co_pu_taken_q;
    co_rd_d       = co_rd_q;
    co_tag_d      = co_tag_q;
    co_value_d    = co_value_q;
    co_st_addr_d  = co_st_addr_q;
    co_st_data_d  = co_st_data_q;
    co_redirect_d = co_redirect_q;
    co_pu_pc_d    = co_pu_pc_q;

    mispred_c = (taken_q[head_q] != pred_q[head_q]);
    commit_c  = rdy && occ_q[head_q] && done_q[head_q];
    flush_c   = commit_c && ((kind_q[head_q] == KIND_JALR) ||
                             ((kind_q[head_q] == KIND_BRANCH) && mispred_c));
    alloc_c   = rdy && alloc_valid && alloc_ready && !flush_c;

    // Writebacks land before the commit clears the head entry.
    if (rdy && !flush_c) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (occ_q[e] && ewb_hit[e]) begin
          value_d[e]  = wb_value[int'(ewb_sel[e])*XLEN +: XLEN];
          target_d[e] = wb_target[int'(ewb_sel[e])*XLEN +: XLEN];
          taken_d[e]  = wb_taken[ewb_sel[e]];
          done_d[e]   = 1'b1;
        end
      end
    end

    if (commit_c) begin
      occ_d[head_q]  = 1'b0;
      done_d[head_q] = 1'b0;
      head_d         = head_q + TAG_W'(1);
      unique case (kind_q[head_q])
        KIND_ALU, KIND_JALR: begin
          co_reg_en_d = 1'b1;
          co_rd_d     = rd_q[head_q];
          co_tag_d    = head_q;
          co_value_d  = value_q[head_q];
          if (kind_q[head_q] == KIND_JALR) begin
            co_flush_d    = 1'b1;
            co_redirect_d = target_q[head_q];
          end
        end
        KIND_STORE: begin
          co_st_en_d   = 1'b1;
          co_st_addr_d = target_q[head_q];
          co_st_data_d = value_q[head_q];
        end
        KIND_BRANCH: begin
          co_pu_en_d    = 1'b1;
          co_pu_pc_d    = pc_q[head_q];
          co_pu_taken_d = taken_q[head_q];
          if (mispred_c) begin
            co_flush_d    = 1'b1;
            co_redirect_d = taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + XLEN'(4);
          end
        end
        default: ;
      endcase
    end

    if (alloc_c) begin
      occ_d[tail_q]  = 1'b1;
      done_d[tail_q] = 1'b0;
      kind_d[tail_q] = rob_kind_e'(alloc_kind);
      rd_d[tail_q]   = alloc_rd;
      pc_d[tail_q]   = alloc_pc;
      pred_d[tail_q] = alloc_pred_taken;
      tail_d         = tail_q + TAG_W'(1);
    end

    count_d = count_q + CNT_W'(alloc_c) - CNT_W'(commit_c);

    if (flush_c) begin
      occ_d   = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      occ_q         <= '0;
      done_q        <= '0;
      pred_q        <= '0;
      taken_q       <= '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        kind_q[e]   <= KIND_ALU;
        rd_q[e]     <= '0;
        pc_q[e]     <= '0;
        value_q[e]  <= '0;
        target_q[e] <= '0;
      end
      co_reg_en_q   <= 1'b0;
      co_st_en_q    <= 1'b0;
      co_flush_q    <= 1'b0;
      co_pu_en_q    <= 1'b0;
      co_pu_taken_q <= 1'b0;
      co_rd_q       <= '0;
      co_tag_q      <= '0;
      co_value_q    <= '0;
      co_st_addr_q  <= '0;
      co_st_data_q  <= '0;
      co_redirect_q <= '0;
      co_pu_pc_q    <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      occ_q         <= occ_d;
      done_q        <= done_d;
      pred_q        <= pred_d;
      taken_q       <= taken_d;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        kind_q[e]   <= kind_d[e];
        rd_q[e]     <= rd_d[e];
        pc_q[e]     <= pc_d[e];
        value_q[e]  <= value_d[e];
        target_q[e] <= target_d[e];
      end
      co_reg_en_q   <= co_reg_en_d;
      co_st_en_q    <= co_st_en_d;
      co_flush_q    <= co_flush_d;
      co_pu_en_q    <= co_pu_en_d;
      co_pu_taken_q <= co_pu_taken_d;
      co_rd_q       <= co_rd_d;
      co_tag_q      <= co_tag_d;
      co_value_q    <= co_value_d;
      co_st_addr_q  <= co_st_addr_d;
      co_st_data_q  <= co_st_data_d;
      co_redirect_q <= co_redirect_d;
      co_pu_pc_q    <= co_pu_pc_d;
    end
  end

  assign count             = count_q;
  assign commit_reg_en     = co_reg_en_q;
  assign commit_rd         = co_rd_q;
  assign commit_tag        = co_tag_q;
  assign commit_value      = co_value_q;
  assign commit_store_en   = co_st_en_q;
  assign commit_store_addr = co_st_addr_q;
  assign commit_store_data = co_st_data_q;
  assign flush             = co_flush_q;
  assign redirect_pc       = co_redirect_q;
  assign pred_upd_en       = co_pu_en_q;
  assign pred_upd_pc       = co_pu_pc_q;
  assign pred_upd_taken    = co_pu_taken_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a cycle table for in-order commit, plus hand sequences
// for fill, reset, branch/JALR flush, same-tag writeback and a wrap-around run with rdy gaps.
module tb_reorder_buffer;
  import rob_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned NWB   = 2;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst, rdy, alloc_valid, alloc_ready, alloc_pred_taken;
  logic [TAG_W-1:0]  alloc_tag;
  logic [1:0]        alloc_kind;
  logic [4:0]        alloc_rd;
  logic [XLEN-1:0]   alloc_pc;
  logic [NWB-1:0]    wb_valid, wb_taken;
  logic [NWB*TAG_W-1:0] wb_tag;
  logic [NWB*XLEN-1:0]  wb_value, wb_target;
  logic [2*TAG_W-1:0] rd_tag;
  logic [1:0]        rd_ready;
  logic [2*XLEN-1:0] rd_value;
  logic              commit_reg_en, commit_store_en, flush, pred_upd_en, pred_upd_taken;
  logic [4:0]        commit_rd;
  logic [TAG_W-1:0]  commit_tag;
  logic [XLEN-1:0]   commit_value, commit_store_addr, commit_store_data, redirect_pc, pred_upd_pc;
  logic [TAG_W:0]    count;

  reorder_buffer #(.DEPTH(DEPTH), .NWB(NWB), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_kind(alloc_kind), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
    .alloc_pred_taken(alloc_pred_taken),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_target(wb_target),
    .wb_taken(wb_taken),
    .rd_tag(rd_tag), .rd_ready(rd_ready), .rd_value(rd_value),
    .commit_reg_en(commit_reg_en), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_value(commit_value),
    .commit_store_en(commit_store_en), .commit_store_addr(commit_store_addr),
    .commit_store_data(commit_store_data),
    .flush(flush), .redirect_pc(redirect_pc),
    .pred_upd_en(pred_upd_en), .pred_upd_pc(pred_upd_pc), .pred_upd_taken(pred_upd_taken),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        av;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        w0v;
    logic [3:0]  w0t;
    logic [31:0] w0val;
    logic [31:0] w0tgt;
    logic        w1v;
    logic [3:0]  w1t;
    logic [31:0] w1val;
    logic        rdy;
    logic [4:0]  e_count;
    logic [3:0]  e_tag;
    logic        e_reg;
    logic        e_st;
    logic [31:0] e_val;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;
  int   n_alloc, n_wb, n_commit, p;
  bit   wr, acc_alloc, acc_wb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; alloc_valid = 1'b0; alloc_kind = KIND_ALU; alloc_rd = '0; alloc_pc = '0;
    alloc_pred_taken = 1'b0; wb_valid = '0; wb_tag = '0; wb_value = '0; wb_target = '0;
    wb_taken = '0; rd_tag = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_alloc(input logic [1:0] k, input logic [4:0] r, input logic [31:0] pc,
                           input logic pred);
    alloc_valid = 1'b1; alloc_kind = k; alloc_rd = r; alloc_pc = pc; alloc_pred_taken = pred;
  endtask

  task automatic set_wb(input int port, input logic [3:0] t, input logic [31:0] v,
                        input logic [31:0] tgt, input logic tk);
    wb_valid[port] = 1'b1;
    wb_tag[port*TAG_W +: TAG_W] = t;
    wb_value[port*XLEN +: XLEN] = v;
    wb_target[port*XLEN +: XLEN] = tgt;
    wb_taken[port] = tk;
  endtask

  function automatic vec_t mk(input logic av, input logic [1:0] kind, input logic [4:0] rd,
                              input logic [31:0] pc, input logic w0v, input logic [3:0] w0t,
                              input logic [31:0] w0val, input logic [31:0] w0tgt,
                              input logic w1v, input logic [3:0] w1t, input logic [31:0] w1val,
                              input logic r, input logic [4:0] ec, input logic [3:0] et,
                              input logic ereg, input logic est, input logic [31:0] ev,
                              input logic [31:0] ea);
    vec_t v;
    v.av = av; v.kind = kind; v.rd = rd; v.pc = pc;
    v.w0v = w0v; v.w0t = w0t; v.w0val = w0val; v.w0tgt = w0tgt;
    v.w1v = w1v; v.w1t = w1t; v.w1val = w1val; v.rdy = r;
    v.e_count = ec; v.e_tag = et; v.e_reg = ereg; v.e_st = est; v.e_val = ev; v.e_addr = ea;
    return v;
  endfunction

  initial begin
    // Reset state
    idle();
    rst = 1'b1;
    repeat (2) step();
    chk("reset count", 64'(count), 64'd0);
    chk("reset alloc_ready", 64'(alloc_ready), 64'd1);
    chk("reset alloc_tag", 64'(alloc_tag), 64'd0);
    chk("reset pulses", 64'({commit_reg_en, commit_store_en, flush, pred_upd_en}), 64'd0);
    chk("reset commit_value", 64'(commit_value), 64'd0);
    rst = 1'b0;
    #1;

    // In-order commit, store, rdy gating and simultaneous alloc/commit
    vq.push_back(mk(1, KIND_ALU,   1, 32'h0,  0, 0, 0, 0,               0, 0, 0,       1, 1, 1, 0, 0, 0, 0));
    vq.push_back(mk(1, KIND_ALU,   2, 32'h4,  0, 0, 0, 0,               0, 0, 0,       1, 2, 2, 0, 0, 0, 0));
    vq.push_back(mk(0, KIND_ALU,   0, 32'h0,  1, 1, 32'h11, 0,          0, 0, 0,       1, 2, 2, 0, 0, 0, 0));
    vq.push_back(mk(0, KIND_ALU,   0, 32'h0,  1, 0, 32'h10, 0,          0, 0, 0,       1, 2, 2, 0, 0, 0, 0));
    vq.push_back(mk(0, KIND_ALU,   0, 32'h0,  0, 0, 0, 0,               0, 0, 0,       1, 1, 2, 1, 0, 32'h10, 0));
    vq.push_back(mk(0, KIND_ALU,   0, 32'h0,  0, 0, 0, 0,               0, 0, 0,       1, 0, 2, 1, 0, 32'h11, 0));
    vq.push_back(mk(1, KIND_STORE, 0, 32'h8,  0, 0, 0, 0,               0, 0, 0,       1, 1, 3, 0, 0, 0, 0));
    vq.push_back(mk(0, KIND_ALU,   0, 32'h0,  1, 2, 32'hDEAD, 32'h1000, 0, 0, 0,       1, 1, 3, 0, 0, 0, 0));
    vq.push_back(mk(0, KIND_ALU,   0, 32'h0,  0, 0, 0, 0,               0, 0, 0,       1, 0, 3, 0, 1, 32'hDEAD, 32'h1000));
    vq.push_back(mk(1, KIND_ALU,   4, 32'hC,  0, 0, 0, 0,               0, 0, 0,       0, 0, 3, 0, 0, 0, 0));
    vq.push_back(mk(1, KIND_ALU,   5, 32'hC,  0, 0, 0, 0,               0, 0, 0,       1, 1, 4, 0, 0, 0, 0));
    vq.push_back(mk(1, KIND_ALU,   6, 32'h10, 1, 3, 32'h33, 0,          0, 0, 0,       1, 2, 5, 0, 0, 0, 0));
    vq.push_back(mk(1, KIND_ALU,   7, 32'h14, 0, 0, 0, 0,               0, 0, 0,       1, 2, 6, 1, 0, 32'h33, 0));
    vq.push_back(mk(0, KIND_ALU,   0, 32'h0,  1, 9, 32'h99, 0,          1, 4, 32'h44,  1, 2, 6, 0, 0, 0, 0));
    vq.push_back(mk(0, KIND_ALU,   0, 32'h0,  0, 0, 0, 0,               0, 0, 0,       1, 1, 6, 1, 0, 32'h44, 0));
    vq.push_back(mk(0, KIND_ALU,   0, 32'h0,  1, 5, 32'h55, 0,          0, 0, 0,       1, 1, 6, 0, 0, 0, 0));
    vq.push_back(mk(0, KIND_ALU,   0, 32'h0,  0, 0, 0, 0,               0, 0, 0,       0, 1, 6, 0, 0, 0, 0));
    vq.push_back(mk(0, KIND_ALU,   0, 32'h0,  0, 0, 0, 0,               0, 0, 0,       1, 0, 6, 1, 0, 32'h55, 0));

    foreach (vq[i]) begin
      idle();
      rdy = vq[i].rdy;
      if (vq[i].av) set_alloc(vq[i].kind, vq[i].rd, vq[i].pc, 1'b0);
      if (vq[i].w0v) set_wb(0, vq[i].w0t, vq[i].w0val, vq[i].w0tgt, 1'b0);
      if (vq[i].w1v) set_wb(1, vq[i].w1t, vq[i].w1val, 32'h0, 1'b0);
      step();
      chk($sformatf("row%0d count", i), 64'(count), 64'(vq[i].e_count));
      chk($sformatf("row%0d alloc_tag", i), 64'(alloc_tag), 64'(vq[i].e_tag));
      chk($sformatf("row%0d reg_en", i), 64'(commit_reg_en), 64'(vq[i].e_reg));
      chk($sformatf("row%0d store_en", i), 64'(commit_store_en), 64'(vq[i].e_st));
      chk($sformatf("row%0d flush", i), 64'(flush), 64'd0);
      if (vq[i].e_reg) chk($sformatf("row%0d value", i), 64'(commit_value), 64'(vq[i].e_val));
      if (vq[i].e_st) begin
        chk($sformatf("row%0d st_data", i), 64'(commit_store_data), 64'(vq[i].e_val));
        chk($sformatf("row%0d st_addr", i), 64'(commit_store_addr), 64'(vq[i].e_addr));
      end
    end
    idle();
    rd_tag = 8'h09;
    #1;
    chk("unoccupied wb ignored", 64'(rd_ready[0]), 64'd0);

    // Fill to DEPTH, overflow ignored, then reset with a commit pending
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_alloc(KIND_ALU, 5'(i), 32'(i * 4), 1'b0);
      #1;
      chk($sformatf("fill tag%0d", i), 64'(alloc_tag), 64'(i));
      step();
    end
    chk("full alloc_ready", 64'(alloc_ready), 64'd0);
    chk("full count", 64'(count), 64'd16);
    step();
    chk("overflow count", 64'(count), 64'd16);
    chk("overflow alloc_tag", 64'(alloc_tag), 64'd0);
    idle();
    set_wb(0, 4'd0, 32'h5, 32'h0, 1'b0);
    step();
    idle();
    #2 rst = 1'b1;
    #1;
    chk("async reset count", 64'(count), 64'd0);
    step();
    chk("reset no commit", 64'(commit_reg_en), 64'd0);
    rst = 1'b0;
    #1;
    chk("reset alloc_ready", 64'(alloc_ready), 64'd1);

    // Same tag from two ports: lowest port wins
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_alloc(KIND_ALU, 5'(i), 32'(i * 4), 1'b0);
      step();
    end
    idle();
    set_wb(0, 4'd3, 32'hA, 32'h0, 1'b0);
    set_wb(1, 4'd3, 32'hB, 32'h0, 1'b0);
    rd_tag = {4'd2, 4'd3};
    #1;
`ifdef ROB_WB_BYPASS_EN
    chk("bypass ready", 64'(rd_ready[0]), 64'd1);
    chk("bypass value", 64'(rd_value[31:0]), 64'hA);
`else
    chk("no-bypass ready", 64'(rd_ready[0]), 64'd0);
`endif
    step();
    wb_valid = '0;
    #1;
    chk("same-tag stored ready", 64'(rd_ready[0]), 64'd1);
    chk("same-tag stored value", 64'(rd_value[31:0]), 64'hA);
    chk("other tag not ready", 64'(rd_ready[1]), 64'd0);
    chk("same-tag count", 64'(count), 64'd4);

    // Mispredicted taken branch flushes; younger writeback and alloc dropped
    do_reset();
    set_alloc(KIND_BRANCH, 5'd0, 32'h100, 1'b0);
    step();
    set_alloc(KIND_ALU, 5'd3, 32'h104, 1'b0);
    step();
    idle();
    set_wb(0, 4'd0, 32'h0, 32'h200, 1'b1);
    step();
    idle();
    set_wb(0, 4'd1, 32'h99, 32'h0, 1'b0);
    set_alloc(KIND_ALU, 5'd4, 32'h108, 1'b0);
    step();
    chk("br pred_upd_en", 64'(pred_upd_en), 64'd1);
    chk("br pred_upd_pc", 64'(pred_upd_pc), 64'h100);
    chk("br pred_upd_taken", 64'(pred_upd_taken), 64'd1);
    chk("br flush", 64'(flush), 64'd1);
    chk("br redirect", 64'(redirect_pc), 64'h200);
    chk("br count", 64'(count), 64'd0);
    chk("br alloc_tag", 64'(alloc_tag), 64'd0);
    idle();
    rd_tag = 8'h01;
    step();
    chk("br pulses clear", 64'({flush, pred_upd_en, commit_reg_en}), 64'd0);
    chk("br dropped wb", 64'(rd_ready[0]), 64'd0);
    chk("br count stays", 64'(count), 64'd0);

    // Correctly predicted branch: predictor update, no flush
    set_alloc(KIND_BRANCH, 5'd0, 32'h300, 1'b1);
    step();
    idle();
    set_wb(0, 4'd0, 32'h0, 32'h400, 1'b1);
    step();
    idle();
    step();
    chk("br2 pred_upd_en", 64'(pred_upd_en), 64'd1);
    chk("br2 flush", 64'(flush), 64'd0);

    // Predicted taken, actually not taken: redirect to pc+4
    set_alloc(KIND_BRANCH, 5'd0, 32'h500, 1'b1);
    step();
    idle();
    set_wb(1, 4'd1, 32'h0, 32'h900, 1'b0);
    step();
    idle();
    step();
    chk("br3 flush", 64'(flush), 64'd1);
    chk("br3 redirect", 64'(redirect_pc), 64'h504);
    chk("br3 taken", 64'(pred_upd_taken), 64'd0);

    // JALR: link value committed, flush to target
    set_alloc(KIND_JALR, 5'd1, 32'h40, 1'b0);
    step();
    idle();
    set_wb(0, 4'd0, 32'h44, 32'h80, 1'b0);
    step();
    idle();
    step();
    chk("jalr reg_en", 64'(commit_reg_en), 64'd1);
    chk("jalr value", 64'(commit_value), 64'h44);
    chk("jalr rd", 64'(commit_rd), 64'd1);
    chk("jalr flush", 64'(flush), 64'd1);
    chk("jalr redirect", 64'(redirect_pc), 64'h80);
    chk("jalr count", 64'(count), 64'd0);

    // 40 alloc/commit pairs across pointer wrap with rdy low every 3rd cycle
    do_reset();
    n_alloc = 0; n_wb = 0; n_commit = 0;
    for (int cyc = 0; cyc < 600 && n_commit < 40; cyc++) begin
      idle();
      wr = ((cyc % 3) != 2);
      rdy = wr;
      if (n_alloc < 40) set_alloc(KIND_ALU, 5'(n_alloc), 32'(n_alloc * 4), 1'b0);
      acc_wb = 1'b0;
      if (n_wb < n_alloc) begin
        p = n_wb % 2;
        set_wb(p, 4'(n_wb), 32'h1000 + 32'(n_wb), 32'h0, 1'b0);
        acc_wb = wr;
      end
      #1;
      acc_alloc = wr && alloc_valid && alloc_ready;
      if (acc_alloc) chk("wrap alloc_tag", 64'(alloc_tag), 64'(n_alloc % 16));
      step();
      if (acc_alloc) n_alloc++;
      if (acc_wb) n_wb++;
      if (!wr)
        chk("wrap quiet", 64'({commit_reg_en, commit_store_en, flush, pred_upd_en}), 64'd0);
      else if (commit_reg_en) begin
        chk("wrap value", 64'(commit_value), 64'h1000 + 64'(n_commit));
        chk("wrap tag", 64'(commit_tag), 64'(n_commit % 16));
        n_commit++;
      end
    end
    chk("wrap commits", 64'(n_commit), 64'd40);
    idle();
    step();
    chk("wrap final count", 64'(count), 64'd0);
    chk("wrap no extra commit", 64'(commit_reg_en), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, minimum 4.
REQ-002 SHALL have parameter NWB, default 2, number of writeback ports.
REQ-003 SHALL have parameter XLEN, default 32, data and address width; TAG_W = log2(DEPTH).
REQ-004 SHALL use one clock; reset is asynchronous and active-high. Ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-005 rdy in 1, global enable; low = no state change.
REQ-006 alloc_valid in 1, alloc_ready out 1, alloc_tag out TAG_W, alloc_kind in 2 (ALU/STORE/BRANCH/JALR), alloc_rd in 5, alloc_pc in XLEN, alloc_pred_taken in 1.
REQ-007 wb_valid in NWB, wb_tag in NWB*TAG_W, wb_value in NWB*XLEN (result, or store data), wb_target in NWB*XLEN (jump target, or store address), wb_taken in NWB.
REQ-008 rd_tag in 2*TAG_W, rd_ready out 2, rd_value out 2*XLEN: two operand-lookup ports.
REQ-009 commit_reg_en out 1, commit_rd out 5, commit_tag out TAG_W, commit_value out XLEN.
REQ-010 commit_store_en out 1, commit_store_addr out XLEN, commit_store_data out XLEN.
REQ-011 flush out 1, redirect_pc out XLEN; pred_upd_en out 1, pred_upd_pc out XLEN, pred_upd_taken out 1; count out TAG_W+1.

Function
REQ-012 SHALL be a circular queue: head, tail and count; pointers wrap modulo DEPTH.
REQ-013 alloc_ready SHALL be 1 iff count < DEPTH; alloc_tag SHALL equal tail combinationally.
REQ-014 alloc_valid & alloc_ready at an edge SHALL write the entry with ready=0 and advance tail; alloc_valid while full SHALL be ignored.
REQ-015 A writeback SHALL set the value, target, taken and ready=1 of an occupied entry; a writeback to an unoccupied tag SHALL be ignored.
REQ-016 If two ports write the same tag in one cycle, the lowest-numbered port SHALL win.
REQ-017 At most one entry SHALL commit per edge: the head, when occupied and ready. The commit outputs are registered and valid for exactly one cycle (latency 1 from the edge where head is ready).
REQ-018 ALU commit SHALL pulse commit_reg_en with rd, tag and value.
REQ-019 STORE commit SHALL pulse commit_store_en with addr and data.
REQ-020 BRANCH commit SHALL pulse pred_upd_en. On wb_taken != pred_taken it SHALL pulse flush, with redirect_pc = taken ? target : pc+4.
REQ-021 JALR commit SHALL pulse commit_reg_en (link value), flush, and redirect_pc = target.
REQ-022 At a flushing commit edge, all entries SHALL become unoccupied, with head=tail=count=0. An allocation or writeback in that same cycle SHALL be dropped.
REQ-023 Simultaneous allocate and commit SHALL leave count unchanged. Commit from full and allocate in the same edge is legal only via a later cycle, because alloc_ready is 0 while full.
REQ-024 A writeback to the head tag SHALL enable commit no earlier than the following edge.
REQ-025 With rdy=0, all pulse outputs SHALL deassert at the next edge and no queue state SHALL change.
REQ-026 rd_ready/rd_value SHALL reflect the addressed entry's stored ready flag and value.

Reset
REQ-027 rst SHALL clear head, tail, count, all ready/occupied flags, and every output register to 0. alloc_ready SHALL read 1 after reset.
REQ-028 rst asserted mid-operation SHALL discard all entries with no commit pulse emitted.

Configuration
REQ-029 Macro ROB_WB_BYPASS_EN defined: rd ports SHALL forward a same-cycle wb_valid match (REQ-016 priority), returning ready=1 and the wb value. Undefined: the lookup SHALL reflect stored state only, i.e. one cycle later.

Structure
REQ-030 Package rob_pkg SHALL hold the alloc_kind encodings, the TAG_W/count width derivation, and a shared XLEN default.
REQ-031 Sub-module rob_wb_merge SHALL implement the NWB-port per-entry priority writeback select; it is reused for bypass.

Verification
REQ-032 Reset, then 16 ALU allocs (DEPTH=16) -> tags 0..15, alloc_ready=0 after the 16th, count=16; a 17th alloc_valid is ignored.
REQ-033 Writeback tag1 then tag0 (values 0x11, 0x10) -> commits in order tag0 then tag1, on consecutive cycles, one cycle after the tag0 writeback.
REQ-034 BRANCH at pc 0x100, pred=0, wb taken=1, target 0x200 -> pred_upd_en=1, flush=1, redirect_pc=0x200, count=0 next cycle; a younger ALU writeback is dropped.
REQ-035 JALR at pc 0x40, wb value 0x44, target 0x80 -> commit_reg_en with value 0x44, flush, redirect_pc=0x80.
REQ-036 Ports 0 and 1 write tag 3 with 0xA and 0xB in one cycle -> stored 0xA; with ROB_WB_BYPASS_EN, rd_tag=3 that cycle returns 0xA, ready=1.
REQ-037 Wrap and rdy: 40 alloc/commit pairs with rdy toggled every 3rd cycle -> strict program order, no lost or duplicated commits, and no pulses during rdy=0.
